rom_page_fetch: RTL and testbench

- Upstream feeder of the LCD page controller. It serves that controller's data_request/data_ack handshake.
- On each request it reads one 8-row display page from a 64-bit-wide synchronous image ROM and transposes it into 64 column bytes.
- It then streams the bytes on data[7:0] at the pace the LCD controller consumes them: one byte per lcd_en period, i.e. 2 clk.

---
 rtl/rom_page_fetch_pkg.sv | 20 ++
 rtl/rom_page_fetch_column_transpose.sv | 21 ++
 rtl/rom_page_fetch.sv | 138 +++++++++++++
 tb/tb_rom_page_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_page_fetch_pkg.sv
// Shared types and constants for the ROM page fetcher.
// Also carries the ENABLED/DISABLED strobe levels used by the LCD controller.
package rom_page_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ACK    = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam int ROM_ROWS   = 8;
    localparam int ROW_W      = 3;
    localparam int ADDR_W     = 7;
    localparam int ROM_ADDR_W = 10;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

endpackage

// File: rtl/rom_page_fetch_column_transpose.sv
// Column select over the 8 x BYTES page buffer.
// Output bit r is pixel row r of column idx_i.
module column_transpose
    import rom_page_fetch_pkg::*;
#(
    parameter int BYTES = 64,
    parameter int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic [ROM_ROWS-1:0][BYTES-1:0] rows_i,
    input  logic [IDX_W-1:0]               idx_i,
    output logic [ROM_ROWS-1:0]            col_o
);

    always_comb begin
        col_o = '0;
        for (int r = 0; r < ROM_ROWS; r++) begin
            col_o[r] = rows_i[r][idx_i];
        end
    end

endmodule

// File: rtl/rom_page_fetch.sv
// Fetches one 8-row page from the image ROM and streams its 64 column bytes.
// Define ROM_PIXEL_INVERT_EN to stream inverse video.
module rom_page_fetch
    import rom_page_fetch_pkg::*;
#(
    parameter int BYTES = 64,
    parameter int PACE  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_request,
    input  logic [ADDR_W-1:0]     addr,
    output logic                  data_ack,
    output logic [7:0]            data,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [BYTES-1:0]      rom_data
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PH_W  = (PACE > 1) ? $clog2(PACE) : 1;

    state_t                        state_q;
    logic [ADDR_W-1:0]             addr_q;
    logic [3:0]                    cnt_q;
    logic [IDX_W-1:0]              idx_q;
    logic [PH_W-1:0]               phase_q;
    logic [ROM_ROWS-1:0][BYTES-1:0] buf_q;
    logic                          ack_q;
    logic                          rom_en_q;
    logic [ROM_ADDR_W-1:0]         rom_addr_q;
    logic [7:0]                    hold_q;

    logic [7:0]       col;
    logic [7:0]       data_d;
    logic [ROW_W-1:0] cap_row;
    logic             streaming;

    column_transpose #(
        .BYTES (BYTES),
        .IDX_W (IDX_W)
    ) u_transpose (
        .rows_i (buf_q),
        .idx_i  (idx_q),
        .col_o  (col)
    );

`ifdef ROM_PIXEL_INVERT_EN
    assign data_d = ~col;
`else
    assign data_d = col;
`endif

    // rom_data lags its read by one clock, so capture row = issue count - 2
    assign cap_row   = ROW_W'(cnt_q - 4'd2);
    assign streaming = (state_q == ACK) || (state_q == STREAM);

    assign data     = streaming ? data_d : hold_q;
    assign data_ack = ack_q;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            phase_q    <= '0;
            buf_q      <= '0;
            ack_q      <= 1'b0;
            rom_en_q   <= DISABLED;
            rom_addr_q <= '0;
            hold_q     <= '0;
        end else begin
            if (streaming) begin
                hold_q <= data_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (data_request) begin
                        addr_q     <= addr;
                        rom_en_q   <= ENABLED;
                        rom_addr_q <= {addr, ROW_W'(0)};
                        cnt_q      <= 4'd1;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!data_request) begin
                        rom_en_q <= DISABLED;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        if (cnt_q >= 4'd2) begin
                            buf_q[cap_row] <= rom_data;
                        end
                        if (cnt_q < 4'd8) begin
                            rom_addr_q <= {addr_q, cnt_q[ROW_W-1:0]};
                            cnt_q      <= cnt_q + 4'd1;
                        end else if (cnt_q == 4'd8) begin
                            rom_en_q <= DISABLED;
                            cnt_q    <= 4'd9;
                        end else begin
                            cnt_q   <= '0;
                            ack_q   <= 1'b1;
                            idx_q   <= '0;
                            phase_q <= '0;
                            state_q <= ACK;
                        end
                    end
                end
                ACK: begin
                    idx_q   <= '0;
                    phase_q <= '0;
                    if (!data_request) begin
                        ack_q   <= 1'b0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (phase_q == PH_W'(PACE - 1)) begin
                        phase_q <= '0;
                        if (idx_q == IDX_W'(BYTES - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_page_fetch.sv
// Table-driven bench for rom_page_fetch with a byte scoreboard.
// Honours ROM_PIXEL_INVERT_EN when computing expected bytes.
module tb_rom_page_fetch;

    typedef logic [7:0][63:0] page_t;

    typedef struct {
        logic [6:0] addr;
        page_t      rows;
        int         k0;
        logic [7:0] e0;
        int         k1;
        logic [7:0] e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_request;
    logic [6:0]  addr;
    logic        data_ack;
    logic [7:0]  data;
    logic [9:0]  rom_addr;
    logic        rom_en;
    logic [63:0] rom_data;

    logic [63:0] rom_mem [0:1023];
    logic [7:0]  sb [$];
    vec_t        vecs [4];

    int checks = 0;
    int errors = 0;

    rom_page_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_request (data_request),
        .addr         (addr),
        .data_ack     (data_ack),
        .data         (data),
        .rom_addr     (rom_addr),
        .rom_en       (rom_en),
        .rom_data     (rom_data)
    );

    always #5 clk = ~clk;

    // synchronous ROM: word valid the clock after the strobe
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] vis(input logic [7:0] b);
`ifdef ROM_PIXEL_INVERT_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    function automatic logic [7:0] model_byte(input page_t rows, input int y);
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = rows[r][y];
        return vis(b);
    endfunction

    task automatic load_page(input vec_t v);
        for (int r = 0; r < 8; r++) rom_mem[{v.addr, 3'(r)}] = v.rows[r];
        for (int y = 0; y < 64; y++) sb.push_back(model_byte(v.rows, y));
    endtask

    // request, check the fetch and ack timing; returns at negedge of R+10
    task automatic fetch_page(input logic [6:0] a);
        @(negedge clk);
        data_request = 1'b1;
        addr = a;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk("rom_en", 32'(rom_en), 32'd1);
                chk("rom_addr", 32'(rom_addr), 32'({a, 3'(c - 1)}));
            end
            chk("data_ack", 32'(data_ack), 32'(c == 10));
        end
    endtask

    task automatic pop_chk(input string name, output logic [7:0] e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 8'hxx;
        chk(name, 32'(data), 32'(e));
    endtask

    task automatic run_page(input vec_t v, input bit chain,
                            input logic [6:0] chain_addr);
        logic [7:0] got [64];
        logic [7:0] e;
        load_page(v);
        fetch_page(v.addr);
        data_request = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            pop_chk("stream_first", e);
            got[k] = data;
            if (k == 0) chk("ack_low", 32'(data_ack), 32'd0);
            @(negedge clk);
            chk("stream_hold", 32'(data), 32'(e));
        end
        // last negedge above is cycle F+128, the STREAM exit cycle
        if (chain) begin
            data_request = 1'b1;
            addr = chain_addr;
        end
        @(negedge clk);
        chk("idle_data_hold", 32'(data), 32'(e));
        chk("idle_rom_en", 32'(rom_en), 32'd0);
        chk("idle_ack", 32'(data_ack), 32'd0);
        chk("spot0", 32'(got[v.k0]), 32'(vis(v.e0)));
        chk("spot1", 32'(got[v.k1]), 32'(vis(v.e1)));
        if (chain) begin
            @(negedge clk);
            chk("chain_rom_en", 32'(rom_en), 32'd1);
            chk("chain_rom_addr", 32'(rom_addr), 32'({chain_addr, 3'd0}));
            data_request = 1'b0;
            repeat (3) @(negedge clk);
            chk("chain_abort_ack", 32'(data_ack), 32'd0);
            chk("chain_abort_en", 32'(rom_en), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] e;

        for (int r = 0; r < 8; r++) begin
            vecs[0].rows[r] = 64'h1 << r;
            vecs[1].rows[r] = 64'hFFFF_FFFF_0000_0000;
            vecs[2].rows[r] = (r % 2 == 1) ? '1 : '0;
            vecs[3].rows[r] = 64'hF0 << (8 * r);
        end
        vecs[0].addr = 7'h15; vecs[0].k0 = 0;  vecs[0].e0 = 8'h01;
        vecs[0].k1 = 8;       vecs[0].e1 = 8'h00;
        vecs[1].addr = 7'h15; vecs[1].k0 = 31; vecs[1].e0 = 8'h00;
        vecs[1].k1 = 32;      vecs[1].e1 = 8'hFF;
        vecs[2].addr = 7'h02; vecs[2].k0 = 0;  vecs[2].e0 = 8'hAA;
        vecs[2].k1 = 63;      vecs[2].e1 = 8'hAA;
        vecs[3].addr = 7'h7F; vecs[3].k0 = 4;  vecs[3].e0 = 8'h01;
        vecs[3].k1 = 63;      vecs[3].e1 = 8'h80;

        rst_n = 1'b0;
        data_request = 1'b0;
        addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(data_ack), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ack0", 32'(data_ack), 32'd0);
        chk("idle_en0", 32'(rom_en), 32'd0);
        chk("idle_data0", 32'(data), 32'd0);

        run_page(vecs[0], 1'b1, 7'h33);
        run_page(vecs[1], 1'b0, 7'h00);

        // abort mid-FETCH: drop request in cycle R+4
        @(negedge clk);
        data_request = 1'b1;
        addr = 7'h40;
        repeat (4) @(negedge clk);
        data_request = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_ack", 32'(data_ack), 32'd0);
        end
        chk("abort_en", 32'(rom_en), 32'd0);
        run_page(vecs[2], 1'b0, 7'h00);

        // reset while streaming byte 20
        load_page(vecs[0]);
        fetch_page(vecs[0].addr);
        data_request = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            pop_chk("pre_reset_stream", e);
            if (k < 20) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(data_ack), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_en", 32'(rom_en), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_page(vecs[0], 1'b0, 7'h00);
        run_page(vecs[3], 1'b0, 7'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
